dpe_demultiplexer: RTL

- Routes one DPE AXI-Stream input to one of five DPE AXI-Stream outputs, selected per packet by a one-hot destination in tuser.
- It is the fan-out counterpart of dpe_multiplexer and sits at the ingress of the per-port DPE output paths.
- A single registered output stage is shared across the five outputs.
- A pause/paused handshake lets the control plane quiesce the block, but only at packet boundaries.

---
 rtl/dpe_demultiplexer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/dpe_demultiplexer.sv
// Purpose : route one DPE stream to one of five outputs, chosen per packet by one-hot tuser[4:0].
// Latency : 1 clk from input acceptance to outk_tvalid through a single shared output register.
// Backpressure: inp_tready = !reg_vld | out[reg_dest]_tready; invalid-destination packets are sunk at full rate.
//
// Build option: define DPE_DEMUX_DROP_CNT_EN to add a 16-bit saturating drop_cnt output
// that counts packets discarded for an invalid destination.
module dpe_demultiplexer #(
    parameter int TDATA_WIDTH = 128,
    parameter int TUSER_WIDTH = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pause,
    output logic                       paused,
    input  logic                       inp_tvalid,
    output logic                       inp_tready,
    input  logic [TDATA_WIDTH-1:0]     inp_tdata,
    input  logic [TDATA_WIDTH/8-1:0]   inp_tkeep,
    input  logic                       inp_tlast,
    input  logic [TUSER_WIDTH-1:0]     inp_tuser,
    output logic                       out0_tvalid,
    input  logic                       out0_tready,
    output logic                       out1_tvalid,
    input  logic                       out1_tready,
    output logic                       out2_tvalid,
    input  logic                       out2_tready,
    output logic                       out3_tvalid,
    input  logic                       out3_tready,
    output logic                       out4_tvalid,
    input  logic                       out4_tready,
    output logic [TDATA_WIDTH-1:0]     out_tdata,
    output logic [TDATA_WIDTH/8-1:0]   out_tkeep,
    output logic                       out_tlast,
    output logic [TUSER_WIDTH-1:0]     out_tuser
`ifdef DPE_DEMUX_DROP_CNT_EN
    ,
    output logic [15:0]                drop_cnt
`endif
);

    typedef struct packed {
        logic [TDATA_WIDTH-1:0]   data;
        logic [TDATA_WIDTH/8-1:0] keep;
        logic                     last;
        logic [TUSER_WIDTH-1:0]   user;
    } beat_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FWD    = 2'd1,
        S_DROP   = 2'd2,
        S_PAUSED = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [4:0]  dest;          // destination of the packet currently in flight
    logic [4:0]  in_sel;
    logic        sel_ok;
    logic [4:0]  out_rdy;
    logic        reg_vld;
    logic [4:0]  reg_dest;      // destination of the beat held in the output register
    beat_t       reg_dat;
    logic        reg_drain;
    logic        fwd_rdy;
    logic        in_acc;
    logic        load;
    logic [4:0]  load_dest;

    assign in_sel  = inp_tuser[4:0];
    assign sel_ok  = (in_sel != 5'd0) && ((in_sel & (in_sel - 5'd1)) == 5'd0);
    assign out_rdy = {out4_tready, out3_tready, out2_tready, out1_tready, out0_tready};

    // Readiness follows the port of the beat being held, which for a packet's first
    // beat is still the previous packet's port: back-to-back packets need no bubble.
    assign reg_drain = reg_vld & (|(out_rdy & reg_dest));
    assign fwd_rdy   = !reg_vld | (|(out_rdy & reg_dest));
    assign in_acc    = inp_tvalid & inp_tready;

    // Only beats of a routed packet enter the output register; dropped beats never do.
    assign load      = in_acc & (((state == S_IDLE) & sel_ok) | (state == S_FWD));
    assign load_dest = (state == S_IDLE) ? in_sel : dest;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; pause is only honoured between packets
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (pause) begin
                    state_nxt = S_PAUSED;
                end else if (in_acc && !inp_tlast) begin
                    state_nxt = sel_ok ? S_FWD : S_DROP;
                end
            end
            S_FWD: begin
                if (in_acc && inp_tlast) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DROP: begin
                if (in_acc && inp_tlast) begin
                    state_nxt = S_IDLE;
                end
            end
            S_PAUSED: begin
                if (!pause) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State outputs; nothing is accepted while reset is asserted
    always_comb begin
        inp_tready = 1'b0;
        paused     = 1'b0;
        if (rst) begin
            case (state)
                S_IDLE:   inp_tready = !pause & fwd_rdy;
                S_FWD:    inp_tready = fwd_rdy;
                S_DROP:   inp_tready = 1'b1;
                S_PAUSED: paused     = !reg_vld;
                default:  inp_tready = 1'b0;
            endcase
        end
    end

    // Latch the destination on the first beat of a valid packet; frozen until tlast
    always_ff @(posedge clk) begin
        if (!rst) begin
            dest <= 5'd0;
        end else if (in_acc && (state == S_IDLE) && sel_ok) begin
            dest <= in_sel;
        end
    end

    // Single-entry output register: load (or replace while draining), else clear on drain
    always_ff @(posedge clk) begin
        if (!rst) begin
            reg_vld  <= 1'b0;
            reg_dest <= 5'd0;
            reg_dat  <= '0;
        end else if (load) begin
            reg_vld      <= 1'b1;
            reg_dest     <= load_dest;
            reg_dat.data <= inp_tdata;
            reg_dat.keep <= inp_tkeep;
            reg_dat.last <= inp_tlast;
            reg_dat.user <= inp_tuser;
        end else if (reg_drain) begin
            reg_vld <= 1'b0;
        end
    end

    assign out0_tvalid = reg_vld & reg_dest[0];
    assign out1_tvalid = reg_vld & reg_dest[1];
    assign out2_tvalid = reg_vld & reg_dest[2];
    assign out3_tvalid = reg_vld & reg_dest[3];
    assign out4_tvalid = reg_vld & reg_dest[4];
    assign out_tdata   = reg_dat.data;
    assign out_tkeep   = reg_dat.keep;
    assign out_tlast   = reg_dat.last;
    assign out_tuser   = reg_dat.user;

`ifdef DPE_DEMUX_DROP_CNT_EN
    // Count each discarded packet once, on the beat that opened it in IDLE; saturate
    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_cnt <= 16'd0;
        end else if (in_acc && (state == S_IDLE) && !sel_ok && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule
